// File: rtl/pid_pkg.sv
// ---------------------------------------------------------------------------
// pid_pkg
//   Shared definitions for the PID error front end: data width, saturation
//   bounds, axis indices and the sequencer state encoding.
// ---------------------------------------------------------------------------
package pid_pkg;

   localparam int W = 24;

   // Two's complement bounds of a W-bit value
   localparam logic [W-1:0] SAT_MAX = 24'h7FFFFF;
   localparam logic [W-1:0] SAT_MIN = 24'h800000;

   // Axis indices used by the time-multiplexed datapath
   localparam logic [1:0] AX_PITCH = 2'd0;
   localparam logic [1:0] AX_ROLL  = 2'd1;
   localparam logic [1:0] AX_YAW   = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ERR  = 3'd1,
      S_INT  = 3'd2,
      S_DER  = 3'd3,
      S_FIRE = 3'd4
   } state_t;

endpackage

// File: rtl/pid_sat_alu.sv
// ---------------------------------------------------------------------------
// pid_sat_alu
//   Combinational saturating add/subtract shared by all three axes.
//   Ports:
//     a, b  in  W  two's complement operands
//     sub   in  1  1 = a - b, 0 = a + b
//     lim   in  W  positive clamp magnitude; result held in [-lim, +lim].
//                  lim == SAT_MAX selects the full W-bit range, whose lower
//                  bound is SAT_MIN (one below -SAT_MAX).
//     y     out W  clamped result
// ---------------------------------------------------------------------------
module pid_sat_alu
   import pid_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   input  logic [W-1:0] lim,
   output logic [W-1:0] y
);

   // Clamp a W+1 bit exact result into [lo, hi] derived from lim
   function automatic logic [W-1:0] clamp_fn(input logic signed [W:0] v,
                                             input logic [W-1:0]      l);
      logic signed [W:0] hi_v;
      logic signed [W:0] lo_v;
      hi_v = $signed({1'b0, l});
      if (l == SAT_MAX) begin
         lo_v = $signed({1'b1, SAT_MIN});
      end else begin
         lo_v = -hi_v;
      end
      if (v > hi_v) begin
         clamp_fn = hi_v[W-1:0];
      end else if (v < lo_v) begin
         clamp_fn = lo_v[W-1:0];
      end else begin
         clamp_fn = v[W-1:0];
      end
   endfunction

   logic signed [W:0] a_ext_s;
   logic signed [W:0] b_ext_s;
   logic signed [W:0] raw_s;

   // One extra bit makes the add/sub exact, so overflow is caught by the clamp
   always_comb begin
      a_ext_s = $signed({a[W-1], a});
      b_ext_s = $signed({b[W-1], b});
      if (sub) begin
         raw_s = a_ext_s - b_ext_s;
      end else begin
         raw_s = a_ext_s + b_ext_s;
      end
      y = clamp_fn(raw_s, lim);
   end

endmodule

// File: rtl/pid_err_sequencer.sv
// ---------------------------------------------------------------------------
// pid_err_sequencer
//   Per-sample front end for cal_pid. For pitch, roll and yaw it computes the
//   error e = sp - meas, a clamped integral i and a derivative d = e - e_prev,
//   one axis per cycle through a single saturating ALU, then pulses
//   cal_pid_en. Owns arming and integrator reset.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     arm                   level, 1 = flight control enabled
//     sample_valid          one-cycle strobe qualifying meas_* / sp_*
//     meas_*, sp_*          measured values and setpoints (W bits)
//     *_error               e per axis
//     i_*_error             integral per axis, held in [-I_LIM, +I_LIM]
//     d_*_error             derivative per axis
//     cal_pid_en            one-cycle pulse, all nine outputs belong to one sample
//     busy                  1 while the sequencer is not idle
//     overrun               sticky, a sample arrived while busy
// ---------------------------------------------------------------------------
module pid_err_sequencer
   import pid_pkg::*;
#(
   parameter logic [W-1:0] I_LIM = 24'd65536
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         arm,
   input  logic         sample_valid,
   input  logic [W-1:0] meas_pitch,
   input  logic [W-1:0] meas_roll,
   input  logic [W-1:0] meas_yaw,
   input  logic [W-1:0] sp_pitch,
   input  logic [W-1:0] sp_roll,
   input  logic [W-1:0] sp_yaw,
   output logic [W-1:0] pitch_error,
   output logic [W-1:0] roll_error,
   output logic [W-1:0] yaw_error,
   output logic [W-1:0] i_pitch_error,
   output logic [W-1:0] i_roll_error,
   output logic [W-1:0] i_yaw_error,
   output logic [W-1:0] d_pitch_error,
   output logic [W-1:0] d_roll_error,
   output logic [W-1:0] d_yaw_error,
   output logic         cal_pid_en,
   output logic         busy,
   output logic         overrun
);

   state_t       state_r;
   state_t       state_next_s;
   logic [1:0]   ax_r;
   logic         last_ax_s;
   logic         accept_s;

   logic         arm_q_r;
   logic         first_flag_r;
   logic         cal_pid_en_r;
   logic         busy_r;
   logic         overrun_r;

   logic [W-1:0] sp_lat_r   [3];
   logic [W-1:0] meas_lat_r [3];
   logic [W-1:0] err_r      [3];
   logic [W-1:0] int_r      [3];
   logic [W-1:0] der_r      [3];
   logic [W-1:0] e_prev_r   [3];

   logic [W-1:0] alu_a_s;
   logic [W-1:0] alu_b_s;
   logic [W-1:0] alu_lim_s;
   logic         alu_sub_s;
   logic [W-1:0] alu_y_s;

   assign last_ax_s = (ax_r == AX_YAW);
   assign accept_s  = (state_r == S_IDLE) & sample_valid & arm;

   pid_sat_alu u_alu (
      .a   (alu_a_s),
      .b   (alu_b_s),
      .sub (alu_sub_s),
      .lim (alu_lim_s),
      .y   (alu_y_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; disarming aborts any sequence in progress
   always_comb begin
      state_next_s = state_r;
      if (!arm) begin
         state_next_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (sample_valid) begin
                  state_next_s = S_ERR;
               end else begin
                  state_next_s = S_IDLE;
               end
            end
            S_ERR: begin
               if (last_ax_s) begin
                  state_next_s = S_INT;
               end else begin
                  state_next_s = S_ERR;
               end
            end
            S_INT: begin
               if (last_ax_s) begin
                  state_next_s = S_DER;
               end else begin
                  state_next_s = S_INT;
               end
            end
            S_DER: begin
               if (last_ax_s) begin
                  state_next_s = S_FIRE;
               end else begin
                  state_next_s = S_DER;
               end
            end
            S_FIRE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
         endcase
      end
   end

   // FSM output logic: ALU operand selection for the current state and axis
   always_comb begin
      alu_a_s   = {W{1'b0}};
      alu_b_s   = {W{1'b0}};
      alu_sub_s = 1'b0;
      alu_lim_s = SAT_MAX;
      case (state_r)
         S_ERR: begin
            alu_a_s   = sp_lat_r[ax_r];
            alu_b_s   = meas_lat_r[ax_r];
            alu_sub_s = 1'b1;
            alu_lim_s = SAT_MAX;
         end
         S_INT: begin
            alu_a_s   = int_r[ax_r];
            alu_b_s   = err_r[ax_r];
            alu_sub_s = 1'b0;
            alu_lim_s = I_LIM;
         end
         S_DER: begin
            alu_a_s   = err_r[ax_r];
            alu_b_s   = e_prev_r[ax_r];
            alu_sub_s = 1'b1;
            alu_lim_s = SAT_MAX;
         end
         default: begin
            alu_a_s   = {W{1'b0}};
            alu_b_s   = {W{1'b0}};
            alu_sub_s = 1'b0;
            alu_lim_s = SAT_MAX;
         end
      endcase
   end

   // Axis counter: walks pitch, roll, yaw within each compute state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ax_r <= AX_PITCH;
      end else if (!arm || state_r == S_IDLE || state_r == S_FIRE || last_ax_s) begin
         ax_r <= AX_PITCH;
      end else begin
         ax_r <= ax_r + 2'd1;
      end
   end

   // Input latches and per-axis result banks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            sp_lat_r[k]   <= {W{1'b0}};
            meas_lat_r[k] <= {W{1'b0}};
            err_r[k]      <= {W{1'b0}};
            int_r[k]      <= {W{1'b0}};
            der_r[k]      <= {W{1'b0}};
            e_prev_r[k]   <= {W{1'b0}};
         end
         first_flag_r <= 1'b0;
      end else if (!arm) begin
         // Disarmed: integrators and history restart from zero on re-arm
         for (int k = 0; k < 3; k++) begin
            err_r[k]    <= {W{1'b0}};
            int_r[k]    <= {W{1'b0}};
            der_r[k]    <= {W{1'b0}};
            e_prev_r[k] <= {W{1'b0}};
         end
         first_flag_r <= 1'b1;
      end else begin
         if (accept_s) begin
            sp_lat_r[AX_PITCH]   <= sp_pitch;
            sp_lat_r[AX_ROLL]    <= sp_roll;
            sp_lat_r[AX_YAW]     <= sp_yaw;
            meas_lat_r[AX_PITCH] <= meas_pitch;
            meas_lat_r[AX_ROLL]  <= meas_roll;
            meas_lat_r[AX_YAW]   <= meas_yaw;
            // arm rising in the same cycle as the sample: no valid history yet
            if (!arm_q_r) begin
               first_flag_r <= 1'b1;
            end
         end
         case (state_r)
            S_ERR: err_r[ax_r] <= alu_y_s;
            S_INT: int_r[ax_r] <= alu_y_s;
            S_DER: begin
               if (first_flag_r) begin
                  der_r[ax_r] <= {W{1'b0}};
               end else begin
                  der_r[ax_r] <= alu_y_s;
               end
               e_prev_r[ax_r] <= err_r[ax_r];
               if (last_ax_s) begin
                  first_flag_r <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered status outputs and arm history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q_r      <= 1'b0;
         cal_pid_en_r <= 1'b0;
         busy_r       <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         arm_q_r      <= arm;
         cal_pid_en_r <= arm & (state_r == S_FIRE);
         busy_r       <= (state_next_s != S_IDLE);
         if (!arm) begin
            overrun_r <= 1'b0;
         end else if (sample_valid && state_r != S_IDLE) begin
            overrun_r <= 1'b1;
         end
      end
   end

   assign pitch_error   = err_r[AX_PITCH];
   assign roll_error    = err_r[AX_ROLL];
   assign yaw_error     = err_r[AX_YAW];
   assign i_pitch_error = int_r[AX_PITCH];
   assign i_roll_error  = int_r[AX_ROLL];
   assign i_yaw_error   = int_r[AX_YAW];
   assign d_pitch_error = der_r[AX_PITCH];
   assign d_roll_error  = der_r[AX_ROLL];
   assign d_yaw_error   = der_r[AX_YAW];
   assign cal_pid_en    = cal_pid_en_r;
   assign busy          = busy_r;
   assign overrun       = overrun_r;

endmodule

// File: tb/tb_pid_err_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pid_err_sequencer
//   Directed, table-driven bench for pid_err_sequencer (I_LIM = 1000).
// ---------------------------------------------------------------------------
module tb_pid_err_sequencer;

   logic        clk;
   logic        rst_n;
   logic        arm;
   logic        sample_valid;
   logic [23:0] meas_pitch, meas_roll, meas_yaw;
   logic [23:0] sp_pitch, sp_roll, sp_yaw;
   logic [23:0] pitch_error, roll_error, yaw_error;
   logic [23:0] i_pitch_error, i_roll_error, i_yaw_error;
   logic [23:0] d_pitch_error, d_roll_error, d_yaw_error;
   logic        cal_pid_en, busy, overrun;

   pid_err_sequencer #(.I_LIM(24'd1000)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .sample_valid(sample_valid),
      .meas_pitch(meas_pitch), .meas_roll(meas_roll), .meas_yaw(meas_yaw),
      .sp_pitch(sp_pitch), .sp_roll(sp_roll), .sp_yaw(sp_yaw),
      .pitch_error(pitch_error), .roll_error(roll_error), .yaw_error(yaw_error),
      .i_pitch_error(i_pitch_error), .i_roll_error(i_roll_error), .i_yaw_error(i_yaw_error),
      .d_pitch_error(d_pitch_error), .d_roll_error(d_roll_error), .d_yaw_error(d_yaw_error),
      .cal_pid_en(cal_pid_en), .busy(busy), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             rearm;
      logic [2:0][23:0] sp;
      logic [2:0][23:0] meas;
      logic [2:0][23:0] e;
      logic [2:0][23:0] i;
      logic [2:0][23:0] d;
   } vec_t;

   vec_t        vecs [7];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          hits;
   int          first_hit;
   logic        busy_abort;
   logic [23:0] cap_e [3];
   logic [23:0] cap_i [3];
   logic [23:0] cap_d [3];

   localparam logic [23:0] N600  = 24'hFFFDA8;  // -600
   localparam logic [23:0] N1000 = 24'hFFFC18;  // -1000
   localparam logic [23:0] N30   = 24'hFFFFE2;  // -30

   function automatic vec_t mk(input logic r,
                               input logic [23:0] s0, s1, s2, m0, m1, m2,
                               input logic [23:0] e0, e1, e2, i0, i1, i2,
                               input logic [23:0] d0, d1, d2);
      vec_t v;
      v.rearm = r;
      v.sp[0] = s0;   v.sp[1] = s1;   v.sp[2] = s2;
      v.meas[0] = m0; v.meas[1] = m1; v.meas[2] = m2;
      v.e[0] = e0;    v.e[1] = e1;    v.e[2] = e2;
      v.i[0] = i0;    v.i[1] = i1;    v.i[2] = i2;
      v.d[0] = d0;    v.d[1] = d1;    v.d[2] = d2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pe"}, pitch_error, 0);   chk({tag, "_re"}, roll_error, 0);
      chk({tag, "_ye"}, yaw_error, 0);     chk({tag, "_pi"}, i_pitch_error, 0);
      chk({tag, "_ri"}, i_roll_error, 0);  chk({tag, "_yi"}, i_yaw_error, 0);
      chk({tag, "_pd"}, d_pitch_error, 0); chk({tag, "_rd"}, d_roll_error, 0);
      chk({tag, "_yd"}, d_yaw_error, 0);   chk({tag, "_en"}, cal_pid_en, 0);
      chk({tag, "_busy"}, busy, 0);        chk({tag, "_ovr"}, overrun, 0);
   endtask

   // Sends one sample (called #1 after a posedge), then watches 12 edges.
   // inj_at: edge offset at which a second sample is offered (0 = none).
   // abort_at: edge offset at which arm is seen low (0 = none).
   task automatic run_sample(input logic [23:0] s0, s1, s2, m0, m1, m2,
                             input int inj_at, input int abort_at);
      sp_pitch = s0; sp_roll = s1; sp_yaw = s2;
      meas_pitch = m0; meas_roll = m1; meas_yaw = m2;
      sample_valid = 1'b1;
      hits = 0; first_hit = -1; busy_abort = 1'bx;
      for (int k = 0; k < 3; k++) begin
         cap_e[k] = 'x; cap_i[k] = 'x; cap_d[k] = 'x;
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
      for (int j = 0; j <= 12; j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
            if (j == abort_at) busy_abort = busy;
            if (cal_pid_en) begin
               hits++;
               if (first_hit < 0) begin
                  first_hit = j;
                  cap_e[0] = pitch_error;   cap_e[1] = roll_error;   cap_e[2] = yaw_error;
                  cap_i[0] = i_pitch_error; cap_i[1] = i_roll_error; cap_i[2] = i_yaw_error;
                  cap_d[0] = d_pitch_error; cap_d[1] = d_roll_error; cap_d[2] = d_yaw_error;
               end
            end
         end
         if (j + 1 == inj_at) begin
            sp_pitch = 24'd9; sp_roll = 24'd9; sp_yaw = 24'd9;
            meas_pitch = 24'd0; meas_roll = 24'd0; meas_yaw = 24'd0;
            sample_valid = 1'b1;
         end else begin
            sample_valid = 1'b0;
         end
         if (j + 1 == abort_at) arm = 1'b0;
      end
      sample_valid = 1'b0;
   endtask

   task automatic chk_caps(input string tag, input vec_t v);
      chk({tag, "_lat"}, first_hit, 10);
      chk({tag, "_pulses"}, hits, 1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_e%0d", tag, k), cap_e[k], v.e[k]);
         chk($sformatf("%s_i%0d", tag, k), cap_i[k], v.i[k]);
         chk($sformatf("%s_d%0d", tag, k), cap_d[k], v.d[k]);
      end
   endtask

   task automatic rearm();
      arm = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      arm = 1'b1;
   endtask

   initial begin
      vec_t v;
      vecs[0] = mk(1'b1, 24'd100, 24'd0, 24'd0, 24'd40, 24'd0, 24'd0,
                   24'd60, 24'd0, 24'd0, 24'd60, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
      vecs[1] = mk(1'b0, 24'd100, 24'd0, 24'd0, 24'd70, 24'd0, 24'd0,
                   24'd30, 24'd0, 24'd0, 24'd90, 24'd0, 24'd0, N30, 24'd0, 24'd0);
      vecs[2] = mk(1'b1, 24'd600, 24'd0, N600, 24'd0, 24'd0, 24'd0,
                   24'd600, 24'd0, N600, 24'd600, 24'd0, N600, 24'd0, 24'd0, 24'd0);
      vecs[3] = mk(1'b0, 24'd600, 24'd0, N600, 24'd0, 24'd0, 24'd0,
                   24'd600, 24'd0, N600, 24'd1000, 24'd0, N1000, 24'd0, 24'd0, 24'd0);
      vecs[4] = mk(1'b0, 24'd600, 24'd0, N600, 24'd0, 24'd0, 24'd0,
                   24'd600, 24'd0, N600, 24'd1000, 24'd0, N1000, 24'd0, 24'd0, 24'd0);
      vecs[5] = mk(1'b0, 24'h7FFFFF, 24'h800000, 24'd5, 24'h800000, 24'h7FFFFF, 24'd5,
                   24'h7FFFFF, 24'h800000, 24'd0, 24'd1000, N1000, N1000,
                   24'h7FFDA7, 24'h800000, 24'd600);
      vecs[6] = mk(1'b0, 24'h800000, 24'd0, 24'd0, 24'h7FFFFF, 24'd0, 24'd0,
                   24'h800000, 24'd0, 24'd0, N1000, N1000, N1000,
                   24'h800000, 24'h7FFFFF, 24'd0);

      rst_n = 1'b0; arm = 1'b0; sample_valid = 1'b0;
      sp_pitch = 24'd0; sp_roll = 24'd0; sp_yaw = 24'd0;
      meas_pitch = 24'd0; meas_roll = 24'd0; meas_yaw = 24'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");

      // Release reset, arm and send a sample all before the first edge
      rst_n = 1'b1;
      arm = 1'b1;
      run_sample(24'd7, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 0, 0);
      v = mk(1'b0, 24'd7, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0,
             24'd7, 24'd0, 24'd0, 24'd7, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
      chk_caps("first_after_reset", v);

      for (int n = 0; n < 7; n++) begin
         if (vecs[n].rearm) rearm();
         run_sample(vecs[n].sp[0], vecs[n].sp[1], vecs[n].sp[2],
                    vecs[n].meas[0], vecs[n].meas[1], vecs[n].meas[2], 0, 0);
         chk_caps($sformatf("vec%0d", n), vecs[n]);
      end

      // Overrun: second sample at N+4 is dropped and flagged
      rearm();
      chk("ovr_clear_pre", overrun, 0);
      run_sample(24'd50, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 4, 0);
      v = mk(1'b0, 24'd50, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0,
             24'd50, 24'd0, 24'd0, 24'd50, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
      chk_caps("ovr_first", v);
      chk("ovr_set", overrun, 1);
      run_sample(24'd50, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 0, 0);
      v = mk(1'b0, 24'd50, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0,
             24'd50, 24'd0, 24'd0, 24'd100, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
      chk_caps("ovr_second", v);
      chk("ovr_sticky", overrun, 1);
      arm = 1'b0;
      @(posedge clk); #1;
      chk("ovr_cleared_by_disarm", overrun, 0);

      // Abort mid-sequence by dropping arm at N+5
      arm = 1'b1;
      @(posedge clk); #1;
      run_sample(24'd100, 24'd200, 24'd300, 24'd0, 24'd0, 24'd0, 0, 5);
      chk("abort_pulses", hits, 0);
      chk("abort_busy", busy_abort, 0);
      chk_all_zero("abort");

      // Re-arm with the sample in the same cycle: derivative must be zero
      arm = 1'b1;
      run_sample(24'd100, 24'd200, 24'd300, 24'd0, 24'd0, 24'd0, 0, 0);
      v = mk(1'b0, 24'd100, 24'd200, 24'd300, 24'd0, 24'd0, 24'd0,
             24'd100, 24'd200, 24'd300, 24'd100, 24'd200, 24'd300, 24'd0, 24'd0, 24'd0);
      chk_caps("rearm_same_cycle", v);

      // Saturated error, then asynchronous reset in the middle of INT
      sp_pitch = 24'h7FFFFF; meas_pitch = 24'h800000;
      sp_roll = 24'd0; meas_roll = 24'd0; sp_yaw = 24'd0; meas_yaw = 24'd0;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("sat_pitch_error", pitch_error, 24'h7FFFFF);
      chk("mid_int_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(posedge clk); #1;

      // Sample in IDLE while disarmed is ignored without setting overrun
      arm = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("disarmed_busy", busy, 0);
      chk("disarmed_ovr", overrun, 0);
      chk("disarmed_en", cal_pid_en, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
